// File: rtl/imem_loader_if.sv
// imem_loader_if
//   Groups the CPU fetch port and the byte-wide program load port of the
//   instruction-memory loader.
//   master : byte source / CPU side (drives pcAddr and the load byte stream)
//   slave  : imem_loader side (returns insData and ld_ready)
//   Signals:
//     pcAddr   - CPU fetch byte address
//     insData  - instruction word for pcAddr
//     ld_valid - load byte valid
//     ld_ready - load byte accepted this cycle when ld_valid=1
//     ld_byte  - load data byte
//     ld_last  - final byte of the program, qualified by ld_valid
interface imem_loader_if;
    logic [31:0] pcAddr;
    logic [31:0] insData;
    logic        ld_valid;
    logic        ld_ready;
    logic [7:0]  ld_byte;
    logic        ld_last;

    modport master (
        output pcAddr,
        output ld_valid,
        output ld_byte,
        output ld_last,
        input  insData,
        input  ld_ready
    );

    modport slave (
        input  pcAddr,
        input  ld_valid,
        input  ld_byte,
        input  ld_last,
        output insData,
        output ld_ready
    );
endinterface

// File: rtl/imem_loader.sv
// imem_loader
//   Instruction memory for a single-cycle CPU that is filled at boot from a
//   byte stream. Bytes are packed little-endian into 32-bit words; the CPU is
//   held in reset until the final byte (ld_last) arrives. Fetches are
//   combinational; anything not backed by loaded data returns NOP_WORD.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   LOAD  | accepting program bytes, CPU held in reset, fetch returns NOP
//   RUN   | program loaded, CPU released, load port closed
//
//   Ports:
//     clk          - system clock, all state on rising edge
//     rst          - synchronous active-high reset
//     bus          - fetch + load port (imem_loader_if.slave)
//     cpu_rst      - reset to the CPU, high while not in RUN
//     load_done    - high in RUN
//     loaded_words - number of valid words written
//     addr_err     - sticky flag: bad fetch address seen in RUN
module imem_loader #(
    parameter int          AW       = 8,
    parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
    input  logic          clk,
    input  logic          rst,
    imem_loader_if.slave  bus,
    output logic          cpu_rst,
    output logic          load_done,
    output logic [AW:0]   loaded_words,
    output logic          addr_err
);

    typedef enum logic {
        S_LOAD = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    localparam logic [AW:0] CAPACITY = {1'b1, {AW{1'b0}}};

    state_t      state_q, state_d;
    logic [1:0]  byte_idx_q, byte_idx_d;
    logic [31:0] asm_q, asm_d;
    logic [AW:0] loaded_words_q, loaded_words_d;
    logic        addr_err_q, addr_err_d;

    // Not reset: stale words stay hidden because reads are bounded by
    // loaded_words.
    logic [31:0] mem [0:(2**AW)-1];

    logic          full;
    logic          ld_ready_int;
    logic          accept;
    logic [31:0]   merged;
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [31:0]   mem_wdata;
    logic [AW-1:0] widx;
    logic          fetch_ok;

    // ------------------------------------------------------------------
    // State register and datapath flops
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_LOAD;
            byte_idx_q     <= 2'd0;
            asm_q          <= 32'd0;
            loaded_words_q <= '0;
            addr_err_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            byte_idx_q     <= byte_idx_d;
            asm_q          <= asm_d;
            loaded_words_q <= loaded_words_d;
            addr_err_q     <= addr_err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we && !rst) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_LOAD: if (accept && bus.ld_last) state_d = S_RUN;
            S_RUN:  state_d = S_RUN;
            default: state_d = S_LOAD;
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode from the state register
    // ------------------------------------------------------------------
    always_comb begin
        cpu_rst      = (state_q != S_RUN);
        load_done    = (state_q == S_RUN);
        ld_ready_int = (state_q == S_LOAD) && !full;
    end

    assign bus.ld_ready = ld_ready_int;
    assign loaded_words = loaded_words_q;
    assign addr_err     = addr_err_q;

    // ------------------------------------------------------------------
    // Byte assembly and word write
    // ------------------------------------------------------------------
    assign full   = (loaded_words_q == CAPACITY);
    assign accept = bus.ld_valid && ld_ready_int;

    // Current byte merged into the assembly word so the completing byte is
    // written in the same edge it arrives.
    always_comb begin
        merged = asm_q;
        case (byte_idx_q)
            2'd0: merged[7:0]   = bus.ld_byte;
            2'd1: merged[15:8]  = bus.ld_byte;
            2'd2: merged[23:16] = bus.ld_byte;
            default: merged[31:24] = bus.ld_byte;
        endcase
    end

    always_comb begin
        byte_idx_d     = byte_idx_q;
        asm_d          = asm_q;
        loaded_words_d = loaded_words_q;
        mem_we         = 1'b0;
        mem_waddr      = loaded_words_q[AW-1:0];
        mem_wdata      = merged;
        if (accept) begin
            if ((byte_idx_q == 2'd3) || bus.ld_last) begin
                // Assembly reg is cleared after each write, so a short final
                // word has its unfilled upper lanes at zero.
                mem_we         = 1'b1;
                loaded_words_d = loaded_words_q + {{AW{1'b0}}, 1'b1};
                asm_d          = 32'd0;
                byte_idx_d     = 2'd0;
            end else begin
                asm_d      = merged;
                byte_idx_d = byte_idx_q + 2'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Fetch path and sticky address error
    // ------------------------------------------------------------------
    assign widx = bus.pcAddr[AW+1:2];

    always_comb begin
        fetch_ok = (state_q == S_RUN)
                && (bus.pcAddr[1:0] == 2'b00)
                && (bus.pcAddr[31:AW+2] == '0)
                && ({1'b0, widx} < loaded_words_q);
        bus.insData = fetch_ok ? mem[widx] : NOP_WORD;
        addr_err_d  = addr_err_q | ((state_q == S_RUN) && !fetch_ok);
    end

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    imem_loader_if if0 ();
    imem_loader_if if1 ();

    logic       cpu_rst0, load_done0, addr_err0;
    logic [8:0] lw0;
    logic       cpu_rst1, load_done1, addr_err1;
    logic [2:0] lw1;

    imem_loader #(.AW(8)) u_dut0 (
        .clk(clk), .rst(rst), .bus(if0.slave),
        .cpu_rst(cpu_rst0), .load_done(load_done0),
        .loaded_words(lw0), .addr_err(addr_err0)
    );

    imem_loader #(.AW(2)) u_dut1 (
        .clk(clk), .rst(rst), .bus(if1.slave),
        .cpu_rst(cpu_rst1), .load_done(load_done1),
        .loaded_words(lw1), .addr_err(addr_err1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic send0(input logic [7:0] b, input logic last);
        if0.ld_valid = 1'b1;
        if0.ld_byte  = b;
        if0.ld_last  = last;
        tick();
        if0.ld_valid = 1'b0;
        if0.ld_last  = 1'b0;
        if0.ld_byte  = 8'h00;
    endtask

    task automatic send1(input logic [7:0] b, input logic last);
        if1.ld_valid = 1'b1;
        if1.ld_byte  = b;
        if1.ld_last  = last;
        tick();
        if1.ld_valid = 1'b0;
        if1.ld_last  = 1'b0;
        if1.ld_byte  = 8'h00;
    endtask

    task automatic test_reset();
        if0.pcAddr = 32'h0;
        do_reset();
        checks++; if (cpu_rst0 !== 1'b1) begin errors++; $display("FAIL reset_cpu_rst: got %b exp 1", cpu_rst0); end
        checks++; if (load_done0 !== 1'b0) begin errors++; $display("FAIL reset_load_done: got %b exp 0", load_done0); end
        checks++; if (if0.ld_ready !== 1'b1) begin errors++; $display("FAIL reset_ld_ready: got %b exp 1", if0.ld_ready); end
        checks++; if (lw0 !== 9'd0) begin errors++; $display("FAIL reset_loaded_words: got %0d exp 0", lw0); end
        checks++; if (addr_err0 !== 1'b0) begin errors++; $display("FAIL reset_addr_err: got %b exp 0", addr_err0); end
        checks++; if (if0.insData !== NOP) begin errors++; $display("FAIL reset_insData: got %h exp %h", if0.insData, NOP); end
    endtask

    task automatic test_single_word();
        do_reset();
        if0.pcAddr = 32'h0;
        send0(8'h13, 1'b0);
        send0(8'h05, 1'b0);
        send0(8'hA0, 1'b0);
        checks++; if (cpu_rst0 !== 1'b1) begin errors++; $display("FAIL single_cpu_rst_before: got %b exp 1", cpu_rst0); end
        send0(8'h00, 1'b1);
        checks++; if (cpu_rst0 !== 1'b0) begin errors++; $display("FAIL single_cpu_rst_after: got %b exp 0", cpu_rst0); end
        checks++; if (load_done0 !== 1'b1) begin errors++; $display("FAIL single_load_done: got %b exp 1", load_done0); end
        checks++; if (lw0 !== 9'd1) begin errors++; $display("FAIL single_loaded_words: got %0d exp 1", lw0); end
        checks++; if (if0.ld_ready !== 1'b0) begin errors++; $display("FAIL single_ld_ready_run: got %b exp 0", if0.ld_ready); end
        checks++; if (if0.insData !== 32'h00A00513) begin errors++; $display("FAIL single_word0: got %h exp 00a00513", if0.insData); end
        tick();
        checks++; if (addr_err0 !== 1'b0) begin errors++; $display("FAIL single_no_err: got %b exp 0", addr_err0); end
        if0.pcAddr = 32'h4;
        #1;
        checks++; if (if0.insData !== NOP) begin errors++; $display("FAIL single_one_past_end: got %h exp %h", if0.insData, NOP); end
        tick();
        checks++; if (addr_err0 !== 1'b1) begin errors++; $display("FAIL single_err_set: got %b exp 1", addr_err0); end
    endtask

    task automatic test_six_bytes();
        do_reset();
        if0.pcAddr = 32'h0;
        for (int i = 1; i <= 6; i++) send0(8'(i), (i == 6));
        checks++; if (lw0 !== 9'd2) begin errors++; $display("FAIL six_loaded_words: got %0d exp 2", lw0); end
        checks++; if (if0.insData !== 32'h04030201) begin errors++; $display("FAIL six_word0: got %h exp 04030201", if0.insData); end
        if0.pcAddr = 32'h4;
        #1;
        checks++; if (if0.insData !== 32'h00000605) begin errors++; $display("FAIL six_word1: got %h exp 00000605", if0.insData); end
        tick();
        checks++; if (addr_err0 !== 1'b0) begin errors++; $display("FAIL six_no_err: got %b exp 0", addr_err0); end
        if0.pcAddr = 32'h8;
        #1;
        checks++; if (if0.insData !== NOP) begin errors++; $display("FAIL six_past_end: got %h exp %h", if0.insData, NOP); end
        if0.pcAddr = 32'h0;
    endtask

    task automatic test_misaligned();
        do_reset();
        // Bad address during LOAD must not raise the error flag.
        if0.pcAddr = 32'h0000_1000;
        send0(8'h44, 1'b0);
        send0(8'h33, 1'b0);
        send0(8'h22, 1'b0);
        send0(8'h11, 1'b1);
        checks++; if (addr_err0 !== 1'b0) begin errors++; $display("FAIL mis_no_err_in_load: got %b exp 0", addr_err0); end
        if0.pcAddr = 32'h0;
        tick();
        checks++; if (if0.insData !== 32'h11223344) begin errors++; $display("FAIL mis_word0: got %h exp 11223344", if0.insData); end
        if0.pcAddr = 32'h2;
        #1;
        checks++; if (if0.insData !== NOP) begin errors++; $display("FAIL mis_insData: got %h exp %h", if0.insData, NOP); end
        tick();
        if0.pcAddr = 32'h0;
        tick();
        tick();
        checks++; if (addr_err0 !== 1'b1) begin errors++; $display("FAIL mis_err_sticky: got %b exp 1", addr_err0); end
        checks++; if (if0.insData !== 32'h11223344) begin errors++; $display("FAIL mis_word0_again: got %h exp 11223344", if0.insData); end
        do_reset();
        checks++; if (addr_err0 !== 1'b0) begin errors++; $display("FAIL mis_err_cleared: got %b exp 0", addr_err0); end
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 0; i < 16; i++) begin
            send1(8'(i), 1'b0);
            if (i == 14) begin
                checks++; if (if1.ld_ready !== 1'b1) begin errors++; $display("FAIL full_ready_before: got %b exp 1", if1.ld_ready); end
            end
        end
        checks++; if (if1.ld_ready !== 1'b0) begin errors++; $display("FAIL full_ready: got %b exp 0", if1.ld_ready); end
        checks++; if (lw1 !== 3'd4) begin errors++; $display("FAIL full_loaded_words: got %0d exp 4", lw1); end
        checks++; if (cpu_rst1 !== 1'b1) begin errors++; $display("FAIL full_cpu_rst: got %b exp 1", cpu_rst1); end
        send1(8'hEE, 1'b1);
        send1(8'hEF, 1'b0);
        checks++; if (lw1 !== 3'd4) begin errors++; $display("FAIL full_extra_words: got %0d exp 4", lw1); end
        checks++; if (cpu_rst1 !== 1'b1) begin errors++; $display("FAIL full_extra_cpu_rst: got %b exp 1", cpu_rst1); end
        checks++; if (load_done1 !== 1'b0) begin errors++; $display("FAIL full_extra_done: got %b exp 0", load_done1); end
        checks++; if (if1.insData !== NOP) begin errors++; $display("FAIL full_insData_load: got %h exp %h", if1.insData, NOP); end
    endtask

    task automatic test_reset_mid_load();
        do_reset();
        if0.pcAddr = 32'h0;
        for (int i = 0; i < 10; i++) send0(8'(8'h20 + i), 1'b0);
        checks++; if (lw0 !== 9'd2) begin errors++; $display("FAIL mid_loaded_words: got %0d exp 2", lw0); end
        checks++; if (if0.insData !== NOP) begin errors++; $display("FAIL mid_insData_load: got %h exp %h", if0.insData, NOP); end
        do_reset();
        checks++; if (lw0 !== 9'd0) begin errors++; $display("FAIL mid_lw_cleared: got %0d exp 0", lw0); end
        send0(8'hAA, 1'b0);
        send0(8'hBB, 1'b0);
        send0(8'hCC, 1'b0);
        send0(8'hDD, 1'b1);
        checks++; if (lw0 !== 9'd1) begin errors++; $display("FAIL mid_reload_words: got %0d exp 1", lw0); end
        checks++; if (if0.insData !== 32'hDDCCBBAA) begin errors++; $display("FAIL mid_word0: got %h exp ddccbbaa", if0.insData); end
        if0.pcAddr = 32'h4;
        #1;
        checks++; if (if0.insData !== NOP) begin errors++; $display("FAIL mid_old_word1: got %h exp %h", if0.insData, NOP); end
        if0.pcAddr = 32'h0;
    endtask

    task automatic test_rst_collision();
        // Reset out of RUN.
        do_reset();
        checks++; if (cpu_rst0 !== 1'b1) begin errors++; $display("FAIL coll_run_reset_cpu_rst: got %b exp 1", cpu_rst0); end
        checks++; if (if0.ld_ready !== 1'b1) begin errors++; $display("FAIL coll_run_reset_ready: got %b exp 1", if0.ld_ready); end
        // One byte pending in lane 0, then rst collides with a 0xFF byte.
        send0(8'h77, 1'b0);
        rst          = 1'b1;
        if0.ld_valid = 1'b1;
        if0.ld_byte  = 8'hFF;
        if0.ld_last  = 1'b1;
        tick();
        rst          = 1'b0;
        if0.ld_valid = 1'b0;
        if0.ld_last  = 1'b0;
        checks++; if (lw0 !== 9'd0) begin errors++; $display("FAIL coll_lw: got %0d exp 0", lw0); end
        checks++; if (cpu_rst0 !== 1'b1) begin errors++; $display("FAIL coll_cpu_rst: got %b exp 1", cpu_rst0); end
        send0(8'h5A, 1'b1);
        checks++; if (lw0 !== 9'd1) begin errors++; $display("FAIL coll_lw_after: got %0d exp 1", lw0); end
        checks++; if (if0.insData !== 32'h0000005A) begin errors++; $display("FAIL coll_lane0: got %h exp 0000005a", if0.insData); end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst = 1'b1;
        if0.pcAddr = 32'h0; if0.ld_valid = 1'b0; if0.ld_byte = 8'h0; if0.ld_last = 1'b0;
        if1.pcAddr = 32'h0; if1.ld_valid = 1'b0; if1.ld_byte = 8'h0; if1.ld_last = 1'b0;
        test_reset();
        test_single_word();
        test_six_bytes();
        test_misaligned();
        test_full();
        test_reset_mid_load();
        test_rst_collision();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
